fnd_scan_driver: RTL
====================

// Module: fnd_scan_driver
// PURPOSE
//  Upstream feeder for the 7-segment decoder. Latches a binary score or count and converts it to BCD
//  with a sequential double-dabble. Time-multiplexes the digits onto one shared 4-bit nibble bus (o_sel),
//  which the decoder turns into segments, and drives active-low digit enables in step with it.
//  Supports leading-zero blanking and saturation on overflow.
// PARAMETERS
//  N_DIGITS     4      number of multiplexed digits (1..8)
//  BIN_W        14     width of i_value
//  REFRESH_DIV  50000  clk cycles each digit stays lit (>=2)
//  LZB          1      1 = blank leading zeros; 0 = show all digits
// PORTS
//  i_clk       in   1         system clock, all state rising-edge
//  i_rst_n     in   1         asynchronous active-low reset
//  i_value     in   BIN_W     binary value to display
//  i_load      in   1         capture i_value; honoured only when o_busy==0
//  o_busy      out  1         conversion in progress
//  o_ovf       out  1         last accepted value > 10^N_DIGITS-1
//  o_sel       out  4         BCD nibble of the active digit, to the decoder sel input
//  o_digit_en  out  N_DIGITS  active-low one-hot digit enable (bit k = digit k, k=0 is LSD)
// BEHAVIOUR
//  Reset (async assert, sync release): o_busy=0, o_ovf=0, o_sel=0, o_digit_en=all 1, display regs=0, idx=0, prescaler=0.
//  Reset mid-conversion aborts the conversion; the display returns to 0.
//  Conversion FSM: IDLE -> SHIFT -> COMMIT -> IDLE.
//   IDLE: i_load=1 at an edge captures i_value, sets o_busy=1, goes to SHIFT.
//    If i_value > 10^N_DIGITS-1, a saturate flag is set.
//   SHIFT: BIN_W cycles; one add-3-then-shift per cycle; BCD scratch width = N_DIGITS+1 digits.
//   COMMIT: one cycle. Writes the display regs (all 9s if saturating), o_ovf=saturate flag, o_busy=0.
//   Latency: display/o_busy/o_ovf update exactly BIN_W+1 cycles after the load edge.
//   i_load while o_busy=1 is ignored (dropped, not queued).
//   i_load in the COMMIT cycle is ignored because o_busy=1 then.
//   The display regs hold the old value for the whole conversion (no flicker).
//  Scan:
//   The prescaler counts 0..REFRESH_DIV-1. At terminal count idx advances and wraps N_DIGITS-1 -> 0.
//   Scanning runs independently of the FSM.
//   o_sel and o_digit_en are registered from idx and the display regs, and change in the same cycle.
//   First edge after reset release: o_digit_en=~1 (digit 0 lit).
//   A display update during a digit slot shows on the next registered output cycle.
//  Blanking (LZB=1):
//   Digit k>0 has its enable held 1 (off) if it and every higher digit are 0; o_sel is still driven.
//   Digit 0 is never blanked, so value 0 shows "0". With LZB=0 every digit is lit in its slot.
//  Overflow saturates the display to all 9s. o_ovf holds until the next COMMIT.
// STRUCTURE
//  Package fnd_pkg: bcd_t (logic [3:0]), DIGITS_OFF constant, function pow10(n) for the saturate limit.
//  Sub-module bin2bcd_seq holds the double-dabble datapath and the IDLE/SHIFT/COMMIT FSM.
//   Ports: start, bin, busy, done, bcd.
//  Top level holds the display regs, prescaler, idx counter, blanking and the output registers.
// TESTING  (bench uses REFRESH_DIV=4, defaults otherwise)
//  Reset: hold i_rst_n=0 -> o_busy=0, o_ovf=0, o_sel=0, o_digit_en=4'b1111.
//   Release -> next edge o_digit_en=4'b1110, o_sel=0.
//  Load 1234: o_busy high for 15 cycles.
//   Then (o_sel,o_digit_en) cycles (4,1110),(3,1101),(2,1011),(1,0111), 4 clk each, then wraps.
//  Load 7, LZB=1: digit 0 slot shows o_sel=7, en=1110; digit 1..3 slots en=1111.
//   Load 0: digit 0 slot o_sel=0, en=1110.
//  Load 12000: after 15 cycles o_ovf=1 and the scan shows 9,9,9,9.
//   Then load 42: o_ovf=0 and the scan shows 2,4 (upper two digits blanked).
//  Load 1234; pulse i_load with 5678 at cycle 5 of busy -> display 1234 (second load dropped).
//   Assert i_rst_n=0 mid-conversion -> immediate reset values, display 0.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared types and helpers for the 7-segment scan driver.
// Holds the conversion FSM states and the saturation-limit helper.
package fnd_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_t;

  localparam logic [7:0] DIGITS_OFF = 8'hFF;

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) r = r * 32'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter.
// One add-3-then-shift step per clock, one commit cycle at the end.
module bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int BIN_W    = 14,
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] bcd
);

  localparam int SW = 4 * (N_DIGITS + 1);
  localparam int CW = $clog2(BIN_W + 1);

  conv_state_t state, nxt;
  logic [BIN_W-1:0]    sr;
  logic [SW-1:0]       acc;
  logic [SW-1:0]       adj;
  logic [SW+BIN_W-1:0] sh;
  logic [CW-1:0]       cnt;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = SHIFT;
      SHIFT:   if (cnt == CW'(BIN_W - 1)) nxt = COMMIT;
      COMMIT:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // add 3 to every digit >= 5, then shift the whole scratch left
  always_comb begin
    adj = acc;
    for (int i = 0; i <= N_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    sh = {adj, sr} << 1;
  end

  // conversion datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (state == IDLE && start) begin
      sr  <= bin;
      acc <= '0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      {acc, sr} <= sh;
      cnt       <= cnt + 1'b1;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == COMMIT);
  assign bcd  = acc[4*N_DIGITS-1:0];

endmodule

// File: rtl/fnd_scan_driver.sv
// Multiplexed 7-segment feeder: BCD conversion, display regs,
// digit scan with leading-zero blanking and overflow saturation.
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int BIN_W       = 14,
  parameter int REFRESH_DIV = 50000,
  parameter int LZB         = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [BIN_W-1:0]    i_value,
  input  logic                i_load,
  output logic                o_busy,
  output logic                o_ovf,
  output logic [3:0]          o_sel,
  output logic [N_DIGITS-1:0] o_digit_en
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [31:0] SAT_LIM = pow10(N_DIGITS) - 32'd1;

  logic                  busy;
  logic                  done;
  logic                  sat;
  logic                  nz;
  logic [4*N_DIGITS-1:0] bcd;
  logic [4*N_DIGITS-1:0] disp;
  bcd_t                  dig [N_DIGITS];
  logic [N_DIGITS-1:0]   blank;
  logic [N_DIGITS-1:0]   en_n;
  logic [PRE_W-1:0]      pre;
  logic [IDX_W-1:0]      idx;

  bin2bcd_seq #(
    .BIN_W   (BIN_W),
    .N_DIGITS(N_DIGITS)
  ) u_conv (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .start(i_load),
    .bin  (i_value),
    .busy (busy),
    .done (done),
    .bcd  (bcd)
  );

  assign o_busy = busy;

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_dig
    assign dig[k] = disp[4*k +: 4];
  end

  // remember whether the accepted value exceeds the display range
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              sat <= 1'b0;
    else if (i_load && !busy)  sat <= 32'(i_value) > SAT_LIM;
  end

  // display regs change only on commit, so the old value stays lit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      disp  <= '0;
      o_ovf <= 1'b0;
    end else if (done) begin
      disp  <= sat ? {N_DIGITS{4'd9}} : bcd;
      o_ovf <= sat;
    end
  end

  // prescaler and digit index, free-running
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_W'(REFRESH_DIV - 1)) begin
      pre <= '0;
      idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // leading-zero blanking, scanned from the top digit down
  always_comb begin
    nz    = 1'b0;
    blank = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      nz       = nz | (dig[k] != 4'd0);
      blank[k] = (LZB != 0) && (k != 0) && !nz;
    end
  end

  // one-hot active-low enable for the current slot
  always_comb begin
    en_n      = DIGITS_OFF[N_DIGITS-1:0];
    en_n[idx] = blank[idx];
  end

  // registered nibble bus and digit enables
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sel      <= 4'd0;
      o_digit_en <= DIGITS_OFF[N_DIGITS-1:0];
    end else begin
      o_sel      <= dig[idx];
      o_digit_en <= en_n;
    end
  end

endmodule
